ncpu32k_ifu: RTL and testbench
==============================

// Module: ncpu32k_ifu
// PURPOSE
//  Instruction fetch unit: owns the fetch PC, drives the BPU lookup, and issues in-order fetch
//  requests on the instruction bus. Buffers returned instructions with their PC and prediction
//  for the decoder (IDU). Sits between the BPU (lookup source) and the IDU (consumer).
//  Accepts redirect/flush from the backend; responses already in flight are discarded.
// PARAMETERS
//  AW           32            address width; PC is word address [AW-3:0]
//  IW           32            instruction width
//  DEPTH        2             max outstanding + buffered instructions (power of 2, >=2)
//  ERST_VECTOR  32'h00000000  byte address fetched first after reset
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous, active-high reset
//  ibus_cmd_valid   out  1     fetch request valid
//  ibus_cmd_ready   in   1     bus accepts request
//  ibus_cmd_addr    out  AW    byte address = {fetch_pc, 2'b00}
//  ibus_dout_valid  in   1     response valid; responses return in request order
//  ibus_dout_ready  out  1     tied 1 (space is reserved at request time)
//  ibus_dout        in   IW    fetched instruction
//  bpu_insn_pc      out  AW-2  current fetch_pc (combinational lookup)
//  bpu_pred_taken   in   1     BPU taken prediction for bpu_insn_pc, same cycle
//  bpu_pred_tgt     in   AW-2  predicted target word address
//  flush            in   1     backend redirect
//  flush_tgt        in   AW-2  redirect target word address
//  idu_valid        out  1     instruction available
//  idu_ready        in   1     IDU consumes
//  idu_insn         out  IW    instruction
//  idu_pc           out  AW-2  its word PC
//  idu_pred_taken   out  1     prediction made at fetch
//  idu_pred_tgt     out  AW-2  predicted target
// BEHAVIOUR
//  - Reset: fetch_pc=ERST_VECTOR[AW-1:2]; cmd_valid=0, idu_valid=0; counters/queues empty.
//    The first request is presented in the first cycle after rst deasserts.
//  - Counters: live (in flight, to be kept), kill (in flight, to be dropped), occ (out FIFO).
//  - ibus_cmd_valid = !rst & !flush & (live+kill+occ < DEPTH).
//    Valid/addr are held stable until ready unless a flush occurs.
//  - Cmd handshake: push {fetch_pc, pred_taken, pred_tgt} into the pending queue; live++.
//    fetch_pc <= pred_taken ? pred_tgt : fetch_pc+1. Wrap modulo 2^(AW-2).
//  - Response when kill>0: drop it, kill--.
//  - Response when kill==0: pop the pending queue, push {insn, pc, pred} into the out FIFO;
//    live--, occ++.
//  - IDU handshake (idu_valid & idu_ready): pop the out FIFO head, occ--.
//    FIFO is first-word-fall-through: head is visible the cycle after push (1-cycle response->IDU latency).
//  - Response push and IDU pop in the same cycle: occ is unchanged, even when the FIFO is full.
//  - flush (highest priority):
//    fetch_pc <= flush_tgt; kill <= kill + live (+ a response arriving this cycle is itself dropped);
//    live <= 0; pending queue and out FIFO are cleared; idu_valid=0 next cycle.
//    cmd_valid is 0 during the flush cycle, so a request is never issued with a stale PC.
//    IDU pop in the flush cycle is ignored.
//  - Back-to-back flushes: the last one wins; kill accumulates correctly.
//  - rst mid-operation: all state returns to reset values. The bus is reset alongside.
//  - Invariant: live+kill+occ <= DEPTH at all times; the response path never back-pressures.
// STRUCTURE
//  - NCPU_AW / NCPU_IW macros come from ncpu32k_config.h. No new shared types.
//  - Sub-module ncpu32k_ifu_fifo: parameterised sync FWFT FIFO (width, depth) with flush.
//    Instantiated twice: pending queue (AW-2+1+AW-2 bits) and out FIFO (IW+AW-2+1+AW-2 bits).
//  - Top level holds fetch_pc, the live/kill/occ counters and the handshake glue.
// TESTING
//  1. Reset, cmd_ready=1, 1-cycle bus, BPU not-taken, idu_ready=1:
//     addrs 0x0,0x4,0x8..., idu_pc 0,1,2 in order, one insn per cycle after fill.
//  2. BPU taken at pc=3, tgt=0x40: next request addr=0x100; idu_pred_taken=1, idu_pred_tgt=0x40 on pc=3.
//  3. idu_ready=0 with DEPTH=2: exactly 2 requests issued, then cmd_valid=0.
//     Raising idu_ready resumes issue the cycle after the first pop.
//  4. Flush with tgt=0x80 while 2 requests are in flight (bus latency 3):
//     both responses dropped; next addr=0x200; idu_pc 0x80 is the first delivered.
//  5. Flush in the same cycle as a response and an IDU pop: response dropped, pop ignored,
//     idu_valid=0 next cycle, kill count correct.
//  6. cmd_ready held 0 for 5 cycles: addr stays stable and fetch_pc does not advance;
//     a flush during the stall changes addr to flush_tgt<<2.

Source files
------------

// File: rtl/ncpu32k_ifu_pkg.sv
// Shared constants and helpers for the ncpu32k instruction fetch unit.
// Default widths mirror NCPU_AW / NCPU_IW from the core configuration.
package ncpu32k_ifu_pkg;

   localparam int NCPU_AW = 32;
   localparam int NCPU_IW = 32;

   // Bits needed to hold a count in 0..depth inclusive
   function automatic int cnt_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ncpu32k_ifu_if.sv
// Instruction bus and decoder handshakes of the fetch unit.
// master = IFU side, slave = bus + IDU side.
interface ncpu32k_ifu_if
   import ncpu32k_ifu_pkg::*;
#(
   parameter int AW = NCPU_AW,
   parameter int IW = NCPU_IW
);

   logic          ibus_cmd_valid;
   logic          ibus_cmd_ready;
   logic [AW-1:0] ibus_cmd_addr;
   logic          ibus_dout_valid;
   logic          ibus_dout_ready;
   logic [IW-1:0] ibus_dout;

   logic          idu_valid;
   logic          idu_ready;
   logic [IW-1:0] idu_insn;
   logic [AW-3:0] idu_pc;
   logic          idu_pred_taken;
   logic [AW-3:0] idu_pred_tgt;

   modport master (
      output ibus_cmd_valid,
      input  ibus_cmd_ready,
      output ibus_cmd_addr,
      input  ibus_dout_valid,
      output ibus_dout_ready,
      input  ibus_dout,
      output idu_valid,
      input  idu_ready,
      output idu_insn,
      output idu_pc,
      output idu_pred_taken,
      output idu_pred_tgt
   );

   modport slave (
      input  ibus_cmd_valid,
      output ibus_cmd_ready,
      input  ibus_cmd_addr,
      output ibus_dout_valid,
      input  ibus_dout_ready,
      output ibus_dout,
      input  idu_valid,
      output idu_ready,
      input  idu_insn,
      input  idu_pc,
      input  idu_pred_taken,
      input  idu_pred_tgt
   );

endinterface

// File: rtl/ncpu32k_ifu_fifo.sv
// Synchronous first-word-fall-through FIFO with a single-cycle flush.
// Head entry is visible the cycle after it is pushed.
module ncpu32k_ifu_fifo
   import ncpu32k_ifu_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rp;
   logic [PTR_W-1:0] wp;
   logic [PTR_W:0]   cnt;

   // Storage needs no reset: only entries below cnt are ever read
   always_ff @(posedge clk) begin
      if (push)
         mem[wp] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else begin
         if (push)
            wp <= wp + PTR_W'(1);
         if (pop)
            rp <= rp + PTR_W'(1);
         cnt <= cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   assign dout  = mem[rp];
   assign valid = (cnt != '0);

endmodule

// File: rtl/ncpu32k_ifu.sv
// Instruction fetch unit: owns fetch_pc, issues in-order fetches,
// drops responses made stale by a redirect, and queues results for the IDU.
module ncpu32k_ifu
   import ncpu32k_ifu_pkg::*;
#(
   parameter int            AW          = NCPU_AW,
   parameter int            IW          = NCPU_IW,
   parameter int            DEPTH       = 2,
   parameter logic [AW-1:0] ERST_VECTOR = '0
) (
   input  logic          clk,
   input  logic          rst,
   ncpu32k_ifu_if.master io,
   output logic [AW-3:0] bpu_insn_pc,
   input  logic          bpu_pred_taken,
   input  logic [AW-3:0] bpu_pred_tgt,
   input  logic          flush,
   input  logic [AW-3:0] flush_tgt
);

   localparam int PW  = AW - 2;
   localparam int CW  = cnt_bits(DEPTH);
   localparam int SW  = CW + 2;
   localparam int QW  = PW + 1 + PW;
   localparam int OW  = IW + QW;

   logic [PW-1:0] fetch_pc;
   logic [CW-1:0] live;
   logic [CW-1:0] kill;
   logic [CW-1:0] occ;
   logic [SW-1:0] used;

   logic          cmd_hs;
   logic          rsp;
   logic          kill_nz;
   logic          rsp_keep;
   logic          idu_pop;

   logic [QW-1:0] pend_din;
   logic [QW-1:0] pend_dout;
   logic          pend_valid;
   logic [OW-1:0] out_din;
   logic [OW-1:0] out_dout;

   assign used = SW'(live) + SW'(kill) + SW'(occ);

   assign io.ibus_cmd_valid  = !rst && !flush && (used < SW'(DEPTH));
   assign io.ibus_cmd_addr   = {fetch_pc, 2'b00};
   assign io.ibus_dout_ready = 1'b1;
   assign bpu_insn_pc        = fetch_pc;

   assign cmd_hs   = io.ibus_cmd_valid && io.ibus_cmd_ready;
   assign rsp      = io.ibus_dout_valid;
   assign kill_nz  = (kill != '0);
   assign rsp_keep = rsp && !kill_nz && !flush && pend_valid;
   assign idu_pop  = io.idu_valid && io.idu_ready && !flush;

   assign pend_din = {fetch_pc, bpu_pred_taken, bpu_pred_tgt};
   assign out_din  = {io.ibus_dout, pend_dout};

   ncpu32k_ifu_fifo #(
      .W     (QW),
      .DEPTH (DEPTH)
   ) u_pend (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (cmd_hs),
      .din   (pend_din),
      .pop   (rsp_keep),
      .dout  (pend_dout),
      .valid (pend_valid)
   );

   ncpu32k_ifu_fifo #(
      .W     (OW),
      .DEPTH (DEPTH)
   ) u_out (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (rsp_keep),
      .din   (out_din),
      .pop   (idu_pop),
      .dout  (out_dout),
      .valid (io.idu_valid)
   );

   assign {io.idu_insn, io.idu_pc,
           io.idu_pred_taken, io.idu_pred_tgt} = out_dout;

   // On redirect every request still out becomes a kill, minus
   // the response that lands this cycle and is dropped on the spot
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= ERST_VECTOR[AW-1:2];
         live     <= '0;
         kill     <= '0;
         occ      <= '0;
      end else if (flush) begin
         fetch_pc <= flush_tgt;
         kill     <= kill + live - CW'(rsp);
         live     <= '0;
         occ      <= '0;
      end else begin
         if (cmd_hs)
            fetch_pc <= bpu_pred_taken ? bpu_pred_tgt
                                       : fetch_pc + PW'(1);
         live <= live + CW'(cmd_hs) - CW'(rsp_keep);
         kill <= kill - CW'(rsp && kill_nz);
         occ  <= occ + CW'(rsp_keep) - CW'(idu_pop);
      end
   end

endmodule

// File: tb/tb_ncpu32k_ifu.sv
// Bench for ncpu32k_ifu: directed scenarios plus random traffic
// against a queue-based model of fetch, kill and delivery.
module tb_ncpu32k_ifu;
   import ncpu32k_ifu_pkg::*;

   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam int PW    = AW - 2;
   localparam int DEPTH = 2;

   typedef struct {
      logic [PW-1:0] pc;
      logic          tk;
      logic [PW-1:0] tg;
      bit            dead;
   } inf_t;

   typedef struct {
      logic [IW-1:0] insn;
      logic [PW-1:0] pc;
      logic          tk;
      logic [PW-1:0] tg;
   } out_t;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } bus_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [PW-1:0] flush_tgt = '0;
   logic [PW-1:0] bpu_insn_pc;
   logic          bpu_pred_taken;
   logic [PW-1:0] bpu_pred_tgt;
   logic          bpu_mode = 1'b0;

   inf_t          minf[$];
   out_t          expq[$];
   bus_t          bq[$];
   logic [AW-1:0] acc[$];
   logic [PW-1:0] dpc[$];
   logic          dtk[$];
   logic [PW-1:0] dtg[$];

   logic [PW-1:0] mpc = '0;
   int            cyc = 0;
   int            lat_lo = 1;
   int            lat_hi = 1;
   int            last_due = 0;
   int            checks = 0;
   int            errors = 0;
   bit            fl_on_rsp = 0;
   bit            hit5 = 0;
   bit            chk_off = 0;

   logic [AW-1:0] e_addr [6] = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h100, 32'h104};
   logic [PW-1:0] e_pc   [6] = '{30'h0, 30'h1, 30'h2, 30'h3, 30'h40, 30'h41};

   always #5 clk = ~clk;

   ncpu32k_ifu_if #(.AW(AW), .IW(IW)) io ();

   ncpu32k_ifu #(
      .AW          (AW),
      .IW          (IW),
      .DEPTH       (DEPTH),
      .ERST_VECTOR (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .io             (io),
      .bpu_insn_pc    (bpu_insn_pc),
      .bpu_pred_taken (bpu_pred_taken),
      .bpu_pred_tgt   (bpu_pred_tgt),
      .flush          (flush),
      .flush_tgt      (flush_tgt)
   );

   function automatic logic [31:0] ph(input logic [PW-1:0] pc);
      return ({2'b00, pc} * 32'h2545f491) ^ 32'h01234567;
   endfunction

   function automatic logic pred_tk(input logic [PW-1:0] pc, input logic m);
      logic [31:0] h;
      h = ph(pc);
      if (m)
         return h[10:8] == 3'd0;
      return pc == PW'(3);
   endfunction

   function automatic logic [PW-1:0] pred_tg(input logic [PW-1:0] pc, input logic m);
      logic [31:0] h;
      h = ph(pc);
      if (m)
         return {22'd0, h[23:16]};
      return PW'(32'h40);
   endfunction

   function automatic logic [IW-1:0] insn_of(input logic [AW-1:0] a);
      return (a * 32'h9e3779b1) ^ 32'h5a5a5a5a;
   endfunction

   assign bpu_pred_taken = pred_tk(bpu_insn_pc, bpu_mode);
   assign bpu_pred_tgt   = pred_tg(bpu_insn_pc, bpu_mode);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] q_acc(input int i);
      if (i < acc.size())
         return 64'(acc[i]);
      return 'x;
   endfunction

   function automatic logic [63:0] q_pc(input int i);
      if (i < dpc.size())
         return 64'(dpc[i]);
      return 'x;
   endfunction

   task automatic clear_logs();
      acc.delete();
      dpc.delete();
      dtk.delete();
      dtg.delete();
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b1;
      flush = 1'b0;
      io.ibus_cmd_ready = 1'b0;
      io.ibus_dout_valid = 1'b0;
      io.ibus_dout = '0;
      io.idu_ready = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         #1;
         chk("rst_cmd_valid", 64'(io.ibus_cmd_valid), 0);
         chk("rst_idu_valid", 64'(io.idu_valid), 0);
         chk("rst_pc", 64'(bpu_insn_pc), 0);
      end
      minf.delete();
      expq.delete();
      bq.delete();
      mpc = '0;
      last_due = 0;
      clear_logs();
   endtask

   // One clock of stimulus, comparison and model update
   task automatic step(input logic cr, input logic ir, input logic fl_in,
                       input logic [PW-1:0] ft);
      bit   rv;
      bit   ecv;
      bit   f;
      int   due;
      bus_t b;
      inf_t h;
      logic [IW-1:0] d;
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      f = fl_in;
      rv = bq.size() > 0 && bq[0].due <= cyc;
      if (fl_on_rsp && rv && io.idu_valid) begin
         f = 1'b1;
         fl_on_rsp = 0;
         hit5 = 1;
      end
      io.ibus_cmd_ready = cr;
      io.idu_ready = ir;
      flush = f;
      flush_tgt = ft;
      io.ibus_dout_valid = rv;
      io.ibus_dout = rv ? insn_of(bq[0].addr) : '0;
      #1;
      ecv = !f && (minf.size() + expq.size() < DEPTH);
      chk("cmd_valid", 64'(io.ibus_cmd_valid), 64'(ecv));
      chk("bpu_pc", 64'(bpu_insn_pc), 64'(mpc));
      chk("dout_ready", 64'(io.ibus_dout_ready), 1);
      if (ecv)
         chk("cmd_addr", 64'(io.ibus_cmd_addr), 64'({mpc, 2'b00}));
      chk("idu_valid", 64'(io.idu_valid), 64'(expq.size() != 0));
      if (chk_off) begin
         chk("s5_idu_off", 64'(io.idu_valid), 0);
         chk_off = 0;
      end
      if (expq.size() != 0) begin
         chk("idu_insn", 64'(io.idu_insn), 64'(expq[0].insn));
         chk("idu_pc", 64'(io.idu_pc), 64'(expq[0].pc));
         chk("idu_tk", 64'(io.idu_pred_taken), 64'(expq[0].tk));
         chk("idu_tg", 64'(io.idu_pred_tgt), 64'(expq[0].tg));
      end
      if (hit5 && f)
         chk_off = 1;
      if (!f && ir && expq.size() != 0) begin
         dpc.push_back(expq[0].pc);
         dtk.push_back(expq[0].tk);
         dtg.push_back(expq[0].tg);
         void'(expq.pop_front());
      end
      if (rv) begin
         b = bq.pop_front();
         d = insn_of(b.addr);
         if (minf.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_tracked: response for %0h with nothing outstanding", b.addr);
         end else begin
            h = minf.pop_front();
            if (!h.dead && !f)
               expq.push_back('{d, h.pc, h.tk, h.tg});
         end
      end
      if (f) begin
         foreach (minf[i])
            minf[i].dead = 1;
         expq.delete();
         mpc = ft;
      end else if (ecv && cr) begin
         acc.push_back({mpc, 2'b00});
         minf.push_back('{mpc, pred_tk(mpc, bpu_mode), pred_tg(mpc, bpu_mode), 0});
         mpc = pred_tk(mpc, bpu_mode) ? pred_tg(mpc, bpu_mode) : mpc + PW'(1);
      end
      if (io.ibus_cmd_valid && cr) begin
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (due <= last_due)
            due = last_due + 1;
         last_due = due;
         bq.push_back('{io.ibus_cmd_addr, due});
      end
   endtask

   initial begin
      io.ibus_cmd_ready = 1'b0;
      io.ibus_dout_valid = 1'b0;
      io.ibus_dout = '0;
      io.idu_ready = 1'b0;

      // Sequential fetch, then a taken prediction at pc 3
      bpu_mode = 1'b0;
      lat_lo = 1;
      lat_hi = 1;
      do_reset(3);
      repeat (20) step(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         chk("s1_addr", q_acc(i), 64'(e_addr[i]));
         chk("s1_idu_pc", q_pc(i), 64'(e_pc[i]));
      end
      if (dtk.size() >= 4) begin
         chk("s2_tk0", 64'(dtk[0]), 0);
         chk("s2_tk3", 64'(dtk[3]), 1);
         chk("s2_tg3", 64'(dtg[3]), 64'h40);
      end else begin
         chk("s2_delivered", 64'(dtk.size()), 4);
      end

      // IDU stalled: fill to DEPTH, then resume after first pop
      do_reset(2);
      repeat (8) step(1'b1, 1'b0, 1'b0, '0);
      chk("s3_issued", 64'(acc.size()), 2);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("s3_hold", 64'(acc.size()), 2);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("s3_resume", 64'(acc.size()), 3);

      // Flush with two requests in flight on a 3-cycle bus
      do_reset(2);
      lat_lo = 3;
      lat_hi = 3;
      repeat (2) step(1'b1, 1'b1, 1'b0, '0);
      clear_logs();
      step(1'b1, 1'b1, 1'b1, 30'h80);
      repeat (15) step(1'b1, 1'b1, 1'b0, '0);
      chk("s4_addr", q_acc(0), 64'h200);
      chk("s4_idu_pc", q_pc(0), 64'h80);

      // Flush coinciding with a response and an IDU pop
      do_reset(2);
      lat_lo = 2;
      lat_hi = 2;
      hit5 = 0;
      fl_on_rsp = 1;
      repeat (30) step(1'b1, 1'b1, 1'b0, 30'h120);
      fl_on_rsp = 0;
      chk("s5_hit", 64'(hit5), 1);
      hit5 = 0;

      // Bus stall holds the request; flush retargets it
      do_reset(2);
      lat_lo = 1;
      lat_hi = 1;
      repeat (5) begin
         step(1'b0, 1'b1, 1'b0, '0);
         chk("s6_addr_stable", 64'(io.ibus_cmd_addr), 0);
      end
      chk("s6_no_issue", 64'(acc.size()), 0);
      step(1'b0, 1'b1, 1'b1, 30'h33);
      step(1'b0, 1'b1, 1'b0, '0);
      chk("s6_flush_addr", 64'(io.ibus_cmd_addr), 64'hcc);
      repeat (5) step(1'b1, 1'b1, 1'b0, '0);
      chk("s6_first_acc", q_acc(0), 64'hcc);

      // Random traffic with a mid-run reset
      bpu_mode = 1'b1;
      lat_lo = 1;
      lat_hi = 4;
      do_reset(2);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500)
            do_reset(2);
         step(($urandom % 4) != 0, ($urandom % 3) != 0,
              ($urandom % 16) == 0, PW'($urandom));
      end
      chk("rand_progress", 64'(dpc.size() > 100), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
